// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared FSM state type and protocol constants
// for the I2C target model (no ports).
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic AckBit      = 1'b0;
  localparam int   BitsPerByte = 8;

endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: SCL/SDA synchroniser and bus-condition detector.
// Ports: clk_i, rst_i, scl_i, sda_i in; sda_o level and one-cycle
// scl_rise_o, scl_fall_o, start_o, stop_o pulses, all aligned.
module i2c_bus_cond #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  if (SyncStages < 2) begin : g_bad_sync
    $error("SyncStages must be at least 2");
  end

  logic [SyncStages-1:0] scl_sync;
  logic [SyncStages-1:0] sda_sync;
  logic                  scl_s;
  logic                  sda_s;
  logic                  scl_q;
  logic                  sda_q;

  assign scl_s = scl_sync[SyncStages-1];
  assign sda_s = sda_sync[SyncStages-1];
  // Previous level is delayed by the pulse register, so it lines
  // up with the edge/condition pulses below.
  assign sda_o = sda_q;

  // Reset to the idle-bus level so release never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SyncStages-2:0], scl_i};
      sda_sync   <= {sda_sync[SyncStages-2:0], sda_i};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      scl_rise_o <= scl_s & ~scl_q;
      scl_fall_o <= ~scl_s & scl_q;
      start_o    <= scl_s & scl_q & sda_q & ~sda_s;
      stop_o     <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_model.sv
// i2c_target_model: I2C target with a byte register file and
// auto-incrementing pointer. Ports: clk_i, rst_i, scl_i, sda_i in;
// sda_oe_o/scl_oe_o pull-low enables, busy_o, wr_valid_o/addr/data.
// Clock stretching is built only with I2C_TARGET_STRETCH_EN.
module i2c_target_model
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TargetAddr    = 7'h50,
  parameter int         Depth         = 16,
  parameter int         SyncStages    = 2,
  parameter int         StretchCycles = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe_o,
  output logic                     scl_oe_o,
  output logic                     busy_o,
  output logic                     wr_valid_o,
  output logic [$clog2(Depth)-1:0] wr_addr_o,
  output logic [7:0]               wr_data_o
);

  localparam int         AW      = $clog2(Depth);
  localparam logic [3:0] AckSlot = 4'(BitsPerByte);

  if (Depth < 2 || Depth > 256 || (Depth & (Depth - 1)) != 0)
  begin : g_bad_depth
    $error("Depth must be a power of 2 in 2..256");
  end
  if (StretchCycles < 1) begin : g_bad_stretch
    $error("StretchCycles must be at least 1");
  end

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_cond #(
    .SyncStages(SyncStages)
  ) u_cond (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_in;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          first_q, first_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          commit;
  logic          wr_valid_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    mem_q [Depth];

  assign byte_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    first_d  = first_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    commit   = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && cnt_q != AckSlot) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == AckSlot) begin
            if (shift_q[7:1] == TargetAddr) begin
              state_d  = ADDR_ACK;
              sda_oe_d = ~AckBit;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (shift_q[0]) begin
              state_d  = RD_BYTE;
              shift_d  = mem_q[ptr_q];
              sda_oe_d = ~mem_q[ptr_q][7];
            end else begin
              state_d  = WR_BYTE;
              first_d  = 1'b1;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && cnt_q != AckSlot) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == AckSlot - 4'd1) begin
              if (first_q) begin
                ptr_d   = byte_in[AW-1:0];
                first_d = 1'b0;
              end else begin
                commit = 1'b1;
                ptr_d  = ptr_q + AW'(1);
              end
            end
          end else if (scl_fall && cnt_q == AckSlot) begin
            state_d  = WR_ACK;
            sda_oe_d = ~AckBit;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d  = WR_BYTE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_rise && cnt_q != AckSlot) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == AckSlot) begin
              state_d  = RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = shift_q << 1;
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          // A fall here always follows the host's ACK rise; a NACK
          // has already left for IGNORE.
          if (scl_rise) begin
            if (sda_s == AckBit) ptr_d = ptr_q + AW'(1);
            else state_d = IGNORE;
          end else if (scl_fall) begin
            state_d  = RD_BYTE;
            cnt_d    = '0;
            shift_d  = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
          end
        end
        IGNORE: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= commit;
      if (commit) begin
        mem_q[ptr_q] <= byte_in;
        wr_addr_q    <= ptr_q;
        wr_data_q    <= byte_in;
      end
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

`ifdef I2C_TARGET_STRETCH_EN
  localparam int SW = $clog2(StretchCycles + 1);

  logic [SW-1:0] stretch_q;
  logic          stretch_go;

  // Stretch the low phase that follows a write ACK or a read's
  // address ACK, giving the target time before the next byte.
  assign stretch_go = scl_fall & ~start & ~stop &
                      ((state_q == WR_ACK) |
                       ((state_q == ADDR_ACK) & shift_q[0]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stretch_q <= '0;
    end else if (stretch_go) begin
      stretch_q <= SW'(StretchCycles);
    end else if (stretch_q != '0) begin
      stretch_q <= stretch_q - SW'(1);
    end
  end

  assign scl_oe_o = (stretch_q != '0);
`else
  assign scl_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_model.sv
// tb_i2c_target_model: bus-level host driving the I2C target,
// checked against a transaction-level register-file model.
module tb_i2c_target_model;

  localparam int Depth   = 16;
  localparam int Stretch = 8;
  localparam int Q       = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_h, sda_h;
  logic       scl, sda;
  logic       sda_oe, scl_oe, busy, wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign scl = scl_h & ~scl_oe;
  assign sda = sda_h & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_model #(
    .TargetAddr   (7'h50),
    .Depth        (Depth),
    .SyncStages   (2),
    .StretchCycles(Stretch)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_oe_o  (sda_oe),
    .scl_oe_o  (scl_oe),
    .busy_o    (busy),
    .wr_valid_o(wr_valid),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: register file and pointer.
  logic [7:0]  mmem [Depth];
  int          mptr;
  logic [7:0]  wbuf [8];
  logic [11:0] wq [$];
  bit          oe_seen;
  bit          scl_oe_seen;
  int          st_len;

  always @(negedge clk) begin
    if (wr_valid) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (scl_oe) scl_oe_seen = 1'b1;
  end

`ifdef I2C_TARGET_STRETCH_EN
  always @(negedge clk) begin
    if (rst) st_len = 0;
    else if (scl_oe) st_len++;
    else if (st_len != 0) begin
      check("stretch_len", st_len, Stretch);
      st_len = 0;
    end
  end
`endif

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_h = 1'b1;
    #1;
    while (scl !== 1'b1 && t < 100) begin
      wait_clk(1);
      t++;
    end
    check("scl_rel", scl, 1'b1);
  endtask

  task automatic put_bit(input logic b, output logic s, output logic oe);
    sda_h = b;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    s  = sda;
    oe = sda_oe;
    wait_clk(Q);
    scl_h = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_start();
    sda_h = 1'b0;
    wait_clk(Q);
    scl_h = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_rstart();
    sda_h = 1'b1;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_h = 1'b0;
    wait_clk(Q);
    scl_h = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_h = 1'b0;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_h = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s, oe;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s, oe);
    put_bit(1'b1, s, oe);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s, oe;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s, oe);
      d[i] = s;
    end
    put_bit(~ack, s, oe);
    check("rd_ack_rel", oe, 1'b0);
  endtask

  task automatic txn_write(input logic [7:0] pb, input int n);
    logic        ack;
    logic [11:0] exq [$];
    wq.delete();
    bus_start();
    write_byte(8'hA0, ack);
    check("aw_ack", ack, 1'b1);
    check("busy_set", busy, 1'b1);
    write_byte(pb, ack);
    check("ptr_ack", ack, 1'b1);
    mptr = int'(pb) % Depth;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check("wd_ack", ack, 1'b1);
      exq.push_back({4'(mptr), wbuf[i]});
      mmem[mptr] = wbuf[i];
      mptr = (mptr + 1) % Depth;
    end
    bus_stop();
    check("busy_clr", busy, 1'b0);
    check("wr_cnt", wq.size(), exq.size());
    for (int i = 0; i < exq.size(); i++)
      check("wr_strobe", (i < wq.size()) ? wq[i] : 12'hfff, exq[i]);
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] pb,
                          input int n);
    logic       ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hA0, ack);
      check("aw_ack", ack, 1'b1);
      write_byte(pb, ack);
      check("ptr_ack", ack, 1'b1);
      mptr = int'(pb) % Depth;
      bus_rstart();
    end
    write_byte(8'hA1, ack);
    check("ar_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      check("rd_data", d, mmem[mptr]);
      if (i != n - 1) mptr = (mptr + 1) % Depth;
    end
    bus_stop();
    check("busy_clr", busy, 1'b0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ack, s, oe;
    rst   = 1'b1;
    scl_h = 1'b1;
    sda_h = 1'b1;
    for (int i = 0; i < Depth; i++) mmem[i] = '0;
    mptr = 0;
    wait_clk(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    check("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    wait_clk(4);

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h5A;
    txn_write(8'h03, 2);
    txn_read(1'b1, 8'h03, 2);

    // Foreign address: no ACK, no drive, no write.
    oe_seen = 1'b0;
    wq.delete();
    bus_start();
    write_byte(8'hA2, ack);
    check("nack_addr", ack, 1'b0);
    write_byte(8'h55, ack);
    check("nack_data", ack, 1'b0);
    bus_stop();
    check("foreign_oe", oe_seen, 1'b0);
    check("foreign_wr", wq.size(), 0);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    txn_write(8'h0F, 2);
    txn_read(1'b1, 8'h13, 1);

    // Half a data byte then STOP: discarded.
    wq.delete();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h04, ack);
    mptr = 4;
    for (int i = 0; i < 4; i++) put_bit(1'b1, s, oe);
    bus_stop();
    check("part_wr", wq.size(), 0);
    check("part_busy", busy, 1'b0);
    txn_read(1'b0, 8'h00, 1);

    for (int k = 0; k < 18; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        txn_write(8'($urandom), $urandom_range(0, 3));
      end else begin
        txn_read($urandom_range(0, 1) == 1, 8'($urandom),
                 $urandom_range(1, 3));
      end
    end

    // Reset while the target pulls SDA low for a data bit.
    wbuf[0] = 8'h3C;
    txn_write(8'h02, 1);
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    bus_rstart();
    write_byte(8'hA1, ack);
    wait_clk(2);
    check("drive_bit", sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_scl", scl_oe, 1'b0);
    sda_h = 1'b1;
    scl_h = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    for (int i = 0; i < Depth; i++) mmem[i] = '0;
    mptr = 0;
    txn_read(1'b0, 8'h00, Depth);

`ifndef I2C_TARGET_STRETCH_EN
    check("no_stretch", scl_oe_seen, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
